// File: rtl/pi1_ram.sv
// pi1 bus word RAM responder with programmable wait states and atomic swap.
// Optional power-up/reset zeroization enabled with PI1RAM_ZEROIZE_EN.
module pi1_ram #(
    parameter int ARCHBITSZ = 32,
    parameter int SIZE      = 256,
    parameter int LATENCY   = 2
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic [1:0]                               pi1_op_i,
    input  logic [ARCHBITSZ-$clog2(ARCHBITSZ/8)-1:0] pi1_addr_i,
    input  logic [ARCHBITSZ-1:0]                     pi1_data_i,
    output logic [ARCHBITSZ-1:0]                     pi1_data_o,
    input  logic [ARCHBITSZ/8-1:0]                   pi1_sel_i,
    output logic                                     pi1_rdy_o,
    output logic [ARCHBITSZ-1:0]                     pi1_mapsz_o
);

    localparam int BW = ARCHBITSZ / 8;
    localparam int AW = ARCHBITSZ - $clog2(BW);
    localparam int IW = $clog2(SIZE);
    localparam int CW = $clog2(LATENCY + 1);

    localparam logic [1:0] OP_NOOP = 2'b00;

`ifdef PI1RAM_ZEROIZE_EN
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BUSY  = 2'b01,
        CLEAR = 2'b10
    } state_t;
    localparam state_t RST_STATE = CLEAR;
`else
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01
    } state_t;
    localparam state_t RST_STATE = IDLE;
`endif

    logic [ARCHBITSZ-1:0] mem [SIZE];

    state_t               state_q;
    state_t               state_d;
    logic [CW-1:0]        cnt_q;
    logic [CW-1:0]        cnt_d;
    logic [1:0]           op_q;
    logic [IW-1:0]        idx_q;
    logic [ARCHBITSZ-1:0] wdat_q;
    logic [BW-1:0]        sel_q;
    logic [ARCHBITSZ-1:0] data_q;

    logic                 accept;
    logic                 mem_we;
    logic                 rd_en;
    logic [IW-1:0]        mem_idx;
    logic [ARCHBITSZ-1:0] mem_wdat;
    logic [BW-1:0]        mem_sel;

`ifdef PI1RAM_ZEROIZE_EN
    logic [IW-1:0]        clr_q;
    logic [IW-1:0]        clr_d;
`endif

    // Upper address bits only alias onto the array.
    logic unused_addr;
    assign unused_addr = ^pi1_addr_i[AW-1:IW];

    assign accept      = (state_q == IDLE) && (pi1_op_i != OP_NOOP);
    assign pi1_rdy_o   = (state_q == IDLE);
    assign pi1_data_o  = data_q;
    assign pi1_mapsz_o = ARCHBITSZ'(SIZE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PI1RAM_ZEROIZE_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clr_q <= '0;
        end else begin
            clr_q <= clr_d;
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mem_we   = 1'b0;
        rd_en    = 1'b0;
        mem_idx  = idx_q;
        mem_wdat = wdat_q;
        mem_sel  = sel_q;
`ifdef PI1RAM_ZEROIZE_EN
        clr_d    = clr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                    cnt_d   = CW'(LATENCY);
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CW'(1);
                // Last wait state: the access commits on this edge.
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    mem_we  = op_q[0];
                    rd_en   = op_q[1];
                end
            end
`ifdef PI1RAM_ZEROIZE_EN
            CLEAR: begin
                mem_we   = 1'b1;
                mem_idx  = clr_q;
                mem_wdat = '0;
                mem_sel  = '1;
                clr_d    = clr_q + IW'(1);
                if (clr_q == IW'(SIZE - 1)) begin
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
        if (rst_i) begin
            mem_we = 1'b0;
            rd_en  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && accept) begin
            op_q   <= pi1_op_i;
            idx_q  <= pi1_addr_i[IW-1:0];
            wdat_q <= pi1_data_i;
            sel_q  <= pi1_sel_i;
        end
    end

    // Read sees the pre-write word, giving the swap its old value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else if (rd_en) begin
            data_q <= mem[idx_q];
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < BW; b++) begin
                if (mem_sel[b]) begin
                    mem[mem_idx][8*b +: 8] <= mem_wdat[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_pi1_ram.sv
// Self-checking bench for pi1_ram: directed scenarios plus random ops
// checked against an array-based reference model.
module tb_pi1_ram;

    localparam int AB   = 32;
    localparam int SZ   = 256;
    localparam int LAT  = 2;

    localparam logic [1:0] WR = 2'b01;
    localparam logic [1:0] RD = 2'b10;
    localparam logic [1:0] SW = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  op  = 2'b00;
    logic [29:0] addr = '0;
    logic [31:0] wdat = '0;
    logic [31:0] rdat;
    logic [3:0]  sel = '0;
    logic        rdy;
    logic [31:0] mapsz;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] model [SZ];
    logic [31:0] last_rd;

    always #5 clk = ~clk;

    pi1_ram #(
        .ARCHBITSZ(AB),
        .SIZE     (SZ),
        .LATENCY  (LAT)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .pi1_op_i   (op),
        .pi1_addr_i (addr),
        .pi1_data_i (wdat),
        .pi1_data_o (rdat),
        .pi1_sel_i  (sel),
        .pi1_rdy_o  (rdy),
        .pi1_mapsz_o(mapsz)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] d,
                                          input logic [3:0]  s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic model_clear();
`ifdef PI1RAM_ZEROIZE_EN
        for (int i = 0; i < SZ; i++) model[i] = '0;
`endif
        last_rd = '0;
    endtask

    task automatic wait_rdy(input string tag);
        int n;
        n = 0;
        while (rdy !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk({tag, ".rdy_timeout"}, 32'(rdy), 32'd1);
    endtask

    // Called at a negedge with rdy high and the op already driven.
    task automatic finish_op(input logic [1:0] o, input logic [29:0] a,
                             input logic [31:0] d, input logic [3:0] s,
                             input string tag);
        int idx;
        idx = int'(a[7:0]);
        @(posedge clk);
        @(negedge clk);
        op = 2'b00;
        chk({tag, ".busy"}, 32'(rdy), 32'd0);
        for (int k = 1; k < LAT; k++) begin
            @(negedge clk);
            chk({tag, ".busy"}, 32'(rdy), 32'd0);
        end
        @(negedge clk);
        chk({tag, ".done"}, 32'(rdy), 32'd1);
        if (o[1]) last_rd = model[idx];
        if (o[0]) model[idx] = merge(model[idx], d, s);
        chk({tag, ".data"}, rdat, last_rd);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [29:0] a,
                          input logic [31:0] d, input logic [3:0] s,
                          input string tag);
        wait_rdy(tag);
        op   = o;
        addr = a;
        wdat = d;
        sel  = s;
        finish_op(o, a, d, s, tag);
    endtask

    task automatic do_reset(input bit hold_read, input string tag);
        int n;
        @(negedge clk);
        rst = 1'b1;
        op  = 2'b00;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk({tag, ".data0"}, rdat, 32'd0);
        model_clear();
        if (hold_read) begin
            op   = RD;
            addr = 30'h7;
            sel  = 4'h0;
        end
        n = 0;
        while (rdy !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
`ifdef PI1RAM_ZEROIZE_EN
        chk({tag, ".clrlen"}, 32'(n), 32'(SZ));
`else
        chk({tag, ".clrlen"}, 32'(n), 32'd0);
`endif
        if (hold_read) finish_op(RD, 30'h7, 32'd0, 4'h0, {tag, ".hold"});
    endtask

    initial begin
        logic [1:0]  ro;
        logic [29:0] ra;
        logic [31:0] rd;
        logic [3:0]  rs;
        int          gap;

        for (int i = 0; i < SZ; i++) model[i] = 'x;
        do_reset(1'b0, "rst");
        chk("mapsz", mapsz, 32'(SZ));

        for (int i = 0; i < SZ; i++)
            run_op(WR, 30'(i), $urandom, 4'hF, "fill");

        run_op(WR, 30'h10, 32'hDEADBEEF, 4'hF, "t1w");
        run_op(RD, 30'h10, 32'h0, 4'h0, "t1r");

        run_op(WR, 30'h20, 32'h11223344, 4'hF, "t2p");
        run_op(WR, 30'h20, 32'hAABBCCDD, 4'h5, "t2w");
        run_op(RD, 30'h20, 32'h0, 4'h0, "t2r");
        chk("t2val", rdat, 32'h11BB33DD);

        run_op(WR, 30'h30, 32'h5, 4'hF, "t3p");
        run_op(SW, 30'h30, 32'h1, 4'hF, "t3s");
        chk("t3old", rdat, 32'h5);
        run_op(RD, 30'h30, 32'h0, 4'h0, "t3r");
        chk("t3new", rdat, 32'h1);

        run_op(SW, 30'h31, 32'h77, 4'h0, "t3z");
        run_op(WR, 30'h31, 32'h99, 4'h0, "t3zw");

        run_op(WR, 30'h105, 32'hCAFE0001, 4'hF, "t4w");
        chk("t4map", mapsz, 32'(SZ));
        run_op(RD, 30'h005, 32'h0, 4'h0, "t4r");
        chk("t4val", rdat, 32'hCAFE0001);

        wait_rdy("t5");
        op   = WR;
        addr = 30'h40;
        wdat = 32'h12345678;
        sel  = 4'hF;
        @(posedge clk);
        @(negedge clk);
        op  = 2'b00;
        rst = 1'b1;
        chk("t5busy", 32'(rdy), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
`ifdef PI1RAM_ZEROIZE_EN
        chk("t5rdy", 32'(rdy), 32'd0);
`else
        chk("t5rdy", 32'(rdy), 32'd1);
`endif
        chk("t5data", rdat, 32'd0);
        model_clear();
        run_op(RD, 30'h40, 32'h0, 4'h0, "t5r");

        run_op(WR, 30'h7, 32'hFFFFFFFF, 4'hF, "t6p");
        do_reset(1'b1, "t6");
        chk("t6map", mapsz, 32'(SZ));

        for (int i = 0; i < 120; i++) begin
            ro = 2'($urandom_range(1, 3));
            ra = 30'($urandom);
            rd = $urandom;
            rs = 4'($urandom_range(0, 15));
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                chk("idle", 32'(rdy), 32'd1);
            end
            run_op(ro, ra, rd, rs, "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pi1_ram.md
Name: pi1_ram

Overview:
- Single-port word-addressed RAM acting as a responder on the pi1 bus.
- Sits on the slave side of the pi1 queue/arbiter, where the PU cluster's aggregated master port is terminated.
- Accepts WRITE, READ and atomic RDWR (swap) operations with byte selects.
- Applies a programmable number of wait states, used to model and serve external memory timing.

Parameters:
- ARCHBITSZ, 32: data width in bits; must be 32 or 64.
- SIZE, 256: number of ARCHBITSZ-wide words; must be a power of 2, at least 2.
- LATENCY, 2: wait-state cycles per operation; must be at least 1.

Ports:
- clk_i, in, 1: clock.
- rst_i, in, 1: reset.
- pi1_op_i, in, 2: 00=NOOP, 01=WRITE, 10=READ, 11=RDWR.
- pi1_addr_i, in, ARCHBITSZ-clog2(ARCHBITSZ/8): word address.
- pi1_data_i, in, ARCHBITSZ: write data from master.
- pi1_data_o, out, ARCHBITSZ: read data to master.
- pi1_sel_i, in, ARCHBITSZ/8: byte-enable mask for writes.
- pi1_rdy_o, out, 1: responder ready; also marks pi1_data_o valid.
- pi1_mapsz_o, out, ARCHBITSZ: constant SIZE, the mapped size in words.

Interface: one clock, clk_i; reset rst_i is synchronous and active-high.

Behaviour:
- Reset, sampled at a clk_i edge:
  - pi1_rdy_o=1, pi1_data_o=0, latency counter=0, FSM=IDLE.
  - Array contents are not modified by reset.
  - Reset overrides every other input in the same cycle.
- Indexing:
  - index = pi1_addr_i[clog2(SIZE)-1:0].
  - Upper address bits are ignored, so accesses alias modulo SIZE.
  - No error is signalled for aliased addresses.
- Acceptance: an op is accepted at edge T when pi1_rdy_o=1 and pi1_op_i!=NOOP.
  - op, index, data and sel are captured into registers.
  - The FSM moves IDLE->BUSY and the counter loads LATENCY.
  - NOOP while IDLE: no state change.
  - Inputs while BUSY are ignored; the master must hold its op until rdy is high.
- BUSY state:
  - pi1_rdy_o=0 for exactly LATENCY cycles, T+1..T+LATENCY.
  - The counter decrements each cycle.
  - On the edge where it reaches 0, the access executes, FSM->IDLE, and pi1_rdy_o=1 from cycle T+LATENCY+1.
- Access on the completion edge:
  - READ: pi1_data_o <= mem[index].
  - WRITE: for each byte b with sel[b]=1, mem[index].byte[b] <= data.byte[b]; pi1_data_o unchanged.
  - RDWR: pi1_data_o <= old mem[index], and the same edge writes the new bytes per sel. This is atomic: no other access interleaves.
  - sel=0 on WRITE or RDWR: no array change, full handshake still performed; RDWR still returns old data.
- pi1_data_o holds its last value until the next READ or RDWR completes.
- Back-to-back ops: an op presented in the cycle rdy returns high is accepted immediately.
  - Throughput is one op per LATENCY+1 cycles.
  - A READ following a WRITE to the same index returns the written data.
- Reset mid-BUSY:
  - The op is abandoned and its write is never committed.
  - rdy returns to 1 in the cycle after the reset edge.
- pi1_mapsz_o is constant SIZE, independent of reset.

Optional Feature:
- Macro: PI1RAM_ZEROIZE_EN.
- With the macro defined:
  - On the first edge with rst_i=0 after reset, a CLEAR state writes zero to index 0, then index 1, and so on, one word per cycle, through SIZE-1.
  - pi1_rdy_o=0 during reset and all SIZE clear cycles; ops presented meanwhile are not accepted.
  - pi1_rdy_o=1 on the cycle after index SIZE-1 is written.
  - Reset during CLEAR restarts clearing from index 0.
  - The reset value of pi1_rdy_o becomes 0.
- Without the macro: no CLEAR state, pi1_rdy_o=1 immediately after reset, and array contents are preserved across reset.

Test Plan:
All scenarios use ARCHBITSZ=32, SIZE=256, LATENCY=2.
1. WRITE addr=0x10, data=0xDEADBEEF, sel=1111 accepted at T, then READ addr=0x10 -> rdy low T+1,T+2, high T+3; READ completes with pi1_data_o=0xDEADBEEF.
2. Word 0x20 holds 0x11223344; WRITE data=0xAABBCCDD, sel=0101, then READ -> 0x11BB33DD.
3. Word 0x30 holds 0x00000005; RDWR data=0x00000001, sel=1111 -> pi1_data_o=0x00000005 at rdy rise; a subsequent READ returns 0x00000001.
4. WRITE addr=0x105, data=0xCAFE0001, then READ addr=0x005 -> 0xCAFE0001 (aliasing); pi1_mapsz_o=256 throughout.
5. WRITE addr=0x40, data=0x12345678 with rst_i pulsed at T+1 -> rdy=1 at T+2; READ 0x40 returns the pre-write value.
6. With PI1RAM_ZEROIZE_EN: preload word 7=0xFFFFFFFF, then reset -> rdy low for 256 cycles after reset release; READ 7 returns 0; a READ held during CLEAR is accepted only once rdy rises.
